// File: rtl/if_pkg.sv
// Shared constants, entry type and address-map helper for the instruction fetch queue.
package if_pkg;

    localparam logic [31:0] RESET_PC   = 32'hBFC0_0000;
    localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;
    localparam logic [31:0] KSEG0_BASE = 32'h8000_0000;
    localparam logic [31:0] KSEG1_TOP  = 32'hBFFF_FFFF;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ifq_entry_t;

    // KSEG0/KSEG1 are unmapped windows onto the low 512 MiB; everything else passes through.
    function automatic logic [31:0] phys_addr(input logic [31:0] va);
        if (va >= KSEG0_BASE && va <= KSEG1_TOP) begin
            return {3'b000, va[28:0]};
        end
        return va;
    endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Synchronous FIFO with push/pop/flush and occupancy count; push while full is legal with a pop.
module ifq_fifo #(
    parameter int DW    = 64,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   aresetn,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_flush,
    input  logic [DW-1:0]          i_data,
    output logic [DW-1:0]          o_data,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_pop   = i_pop && !w_empty;
    assign w_push  = i_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (!aresetn || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction fetch front end: SRAM-like request issue, in-order response tracking and decode queue.
// Optional macro IFQ_BYPASS_EN lets a response reach decode in the same cycle when the queue is empty.
module if_fetch_queue #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 4,
    parameter int MAX_OUT = 2
) (
    input  logic                   clk,
    input  logic                   aresetn,
    input  logic                   exc_valid,
    input  logic                   redirect_valid,
    input  logic [WIDTH-1:0]       redirect_pc,
    output logic                   deq_valid,
    input  logic                   deq_ready,
    output logic [WIDTH-1:0]       deq_pc,
    output logic [WIDTH-1:0]       deq_instr,
    output logic                   inst_req,
    output logic                   inst_wr,
    output logic [1:0]             inst_size,
    output logic [31:0]            inst_addr,
    output logic [31:0]            inst_wdata,
    input  logic [31:0]            inst_rdata,
    input  logic                   inst_addr_ok,
    input  logic                   inst_data_ok,
    output logic [$clog2(DEPTH):0] q_count
);
    import if_pkg::*;

    localparam int QCW = $clog2(DEPTH) + 1;
    localparam int OCW = $clog2(MAX_OUT) + 1;
    localparam int EW  = 2 * WIDTH;

    logic [WIDTH-1:0] r_fetch_pc;
    logic [WIDTH-1:0] r_lock_pc;
    logic             r_lock;
    logic             r_stale;
    logic [OCW-1:0]   r_discard;

    logic             w_redirect;
    logic [WIDTH-1:0] w_target;
    logic [WIDTH-1:0] w_req_pc;
    logic [WIDTH-1:0] w_pend_pc;
    logic [OCW-1:0]   w_out;
    logic [QCW-1:0]   w_qcount;
    logic [31:0]      w_occ;
    logic             w_can_issue;
    logic             w_req;
    logic             w_accept;
    logic             w_drop;
    logic             w_keep;
    logic             w_q_empty;
    logic             w_q_push;
    logic             w_q_pop;
    logic [EW-1:0]    w_q_wdata;
    logic [EW-1:0]    w_q_rdata;

    assign w_redirect = exc_valid || redirect_valid;
    assign w_target   = exc_valid ? WIDTH'(EXC_VECTOR) : redirect_pc;

    // Queue occupancy plus in-flight requests reserves a slot for every response before it is asked for.
    assign w_occ       = 32'(w_qcount) + 32'(w_out);
    assign w_can_issue = (r_discard == '0) && (32'(w_out) < 32'(MAX_OUT)) && (w_occ < 32'(DEPTH));
    assign w_req       = aresetn && (r_lock || w_can_issue);
    assign w_req_pc    = r_lock ? r_lock_pc : r_fetch_pc;
    assign w_accept    = w_req && inst_addr_ok;
    assign w_drop      = (r_discard != '0);
    assign w_keep      = inst_data_ok && !w_drop && !w_redirect;

    assign inst_req   = w_req;
    assign inst_addr  = phys_addr(32'(w_req_pc));
    assign inst_wr    = 1'b0;
    assign inst_size  = 2'b10;
    assign inst_wdata = 32'h0;

    ifq_fifo #(.DW(WIDTH), .DEPTH(MAX_OUT)) u_pend (
        .clk     (clk),
        .aresetn (aresetn),
        .i_push  (w_accept),
        .i_pop   (inst_data_ok),
        .i_flush (1'b0),
        .i_data  (w_req_pc),
        .o_data  (w_pend_pc),
        .o_count (w_out)
    );

    assign w_q_wdata = {w_pend_pc, WIDTH'(inst_rdata)};
    assign w_q_empty = (w_qcount == '0);

    ifq_fifo #(.DW(EW), .DEPTH(DEPTH)) u_queue (
        .clk     (clk),
        .aresetn (aresetn),
        .i_push  (w_q_push),
        .i_pop   (w_q_pop),
        .i_flush (w_redirect),
        .i_data  (w_q_wdata),
        .o_data  (w_q_rdata),
        .o_count (w_qcount)
    );

    // Decode handshake: an entry transfers on any cycle with deq_valid && deq_ready; the
    // producer holds deq_pc/deq_instr stable while deq_valid is high and deq_ready is low.
`ifdef IFQ_BYPASS_EN
    logic w_bypass;
    assign w_bypass  = w_q_empty && w_keep;
    assign w_q_push  = w_keep && !(w_bypass && deq_ready);
    assign deq_valid = aresetn && (!w_q_empty || w_bypass);
    assign deq_pc    = w_q_empty ? w_pend_pc : w_q_rdata[EW-1:WIDTH];
    assign deq_instr = w_q_empty ? WIDTH'(inst_rdata) : w_q_rdata[WIDTH-1:0];
`else
    assign w_q_push  = w_keep;
    assign deq_valid = aresetn && !w_q_empty;
    assign deq_pc    = w_q_rdata[EW-1:WIDTH];
    assign deq_instr = w_q_rdata[WIDTH-1:0];
`endif

    assign w_q_pop = deq_valid && deq_ready && !w_q_empty;
    assign q_count = w_qcount;

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_fetch_pc <= WIDTH'(RESET_PC);
            r_lock_pc  <= '0;
            r_lock     <= 1'b0;
            r_stale    <= 1'b0;
            r_discard  <= '0;
        end else begin
            if (w_redirect) begin
                r_fetch_pc <= w_target;
            end else if (w_accept && !r_stale) begin
                r_fetch_pc <= r_fetch_pc + WIDTH'(4);
            end

            // A stale locked request must not advance the already-redirected fetch PC.
            if (w_req && !inst_addr_ok) begin
                r_lock    <= 1'b1;
                r_lock_pc <= w_req_pc;
                if (w_redirect) r_stale <= 1'b1;
            end else if (w_accept) begin
                r_lock  <= 1'b0;
                r_stale <= 1'b0;
            end

            // After a redirect every response still owed (including a locked request) is stale.
            if (w_redirect) begin
                r_discard <= w_out + OCW'(w_req) - OCW'(inst_data_ok);
            end else if (inst_data_ok && w_drop) begin
                r_discard <= r_discard - OCW'(1);
            end
        end
    end

endmodule
